// File: rtl/complex_dot_accumulator_if.sv
// -----------------------------------------------------------------------------
// complex_dot_accumulator_if
//
// Purpose:
//   Bundles the product-input handshake, the flush strobe, the result-output
//   handshake and the term index of complex_dot_accumulator.
//
// Parameters:
//   K      products summed per output element (>= 1)
//   IN_W   width of each signed product component
//   ACC_W  width of the signed accumulator / output components
//
// Signals:
//   in_real, in_imag  signed product components (IN_W)
//   in_valid          product present
//   in_ready          block accepts the product this cycle
//   flush             discard the partial sum
//   out_real,out_imag signed accumulated result (ACC_W)
//   out_valid         result present
//   out_ready         downstream accepts the result
//   term_idx          index of the next product to be accepted
//
// Modports:
//   master  producer / consumer side (multiplier array + writeback)
//   slave   accumulator side
// -----------------------------------------------------------------------------
interface complex_dot_accumulator_if #(
   parameter int K     = 4,
   parameter int IN_W  = 16,
   parameter int ACC_W = 24
);
   localparam int TIDX_W = (K > 1) ? $clog2(K) : 1;

   logic signed [IN_W-1:0]  in_real;
   logic signed [IN_W-1:0]  in_imag;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic signed [ACC_W-1:0] out_real;
   logic signed [ACC_W-1:0] out_imag;
   logic                    out_valid;
   logic                    out_ready;
   logic [TIDX_W-1:0]       term_idx;

   modport master (
      output in_real, in_imag, in_valid, flush, out_ready,
      input  in_ready, out_real, out_imag, out_valid, term_idx
   );

   modport slave (
      input  in_real, in_imag, in_valid, flush, out_ready,
      output in_ready, out_real, out_imag, out_valid, term_idx
   );
endinterface

// File: rtl/complex_dot_accumulator.sv
// -----------------------------------------------------------------------------
// complex_dot_accumulator
//
// Purpose:
//   Accumulates K signed complex products into one complex dot-product term
//   (one element of the result matrix) and presents it on a valid/ready
//   output, holding it until the writeback stage takes it.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   complex_dot_accumulator_if.slave
//           in_real/in_imag/in_valid/in_ready  product input handshake
//           flush                              discard the partial sum
//           out_real/out_imag/out_valid/out_ready  result handshake
//           term_idx                           index of next product
//
// Parameters:
//   K (>=1), IN_W, ACC_W (>= IN_W + clog2(K))
//
// Build option:
//   CDA_SATURATE_EN  when defined, every accumulation step clamps each
//                    component to the signed ACC_W range; when undefined the
//                    arithmetic wraps in two's complement.
//
// Operation:
//   ACCUM: in_ready = !flush. Each accepted product is added to the running
//          sum; the K-th product writes acc + product into the output
//          registers, clears the sum and moves to HOLD.
//   HOLD:  out_valid = 1, in_ready = 0. out_ready returns to ACCUM next
//          cycle; no product is accepted in the hand-off cycle.
//   flush in ACCUM clears the partial sum and blocks acceptance that cycle;
//   flush in HOLD is ignored.
// -----------------------------------------------------------------------------
module complex_dot_accumulator #(
   parameter int K     = 4,
   parameter int IN_W  = 16,
   parameter int ACC_W = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   complex_dot_accumulator_if.slave   bus
);

   localparam int TIDX_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [TIDX_W-1:0] LAST_IDX = TIDX_W'(K - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                  state_q;
   logic signed [ACC_W-1:0] acc_real_q;
   logic signed [ACC_W-1:0] acc_imag_q;
   logic signed [ACC_W-1:0] out_real_q;
   logic signed [ACC_W-1:0] out_imag_q;
   logic [TIDX_W-1:0]       term_idx_q;

   logic signed [ACC_W-1:0] in_real_ext;
   logic signed [ACC_W-1:0] in_imag_ext;
   logic signed [ACC_W-1:0] sum_real_d;
   logic signed [ACC_W-1:0] sum_imag_d;
   logic                    in_ready_w;
   logic                    accept_w;

   // One accumulation step for a single component.
   function automatic logic signed [ACC_W-1:0] acc_add(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] b
   );
`ifdef CDA_SATURATE_EN
      logic [ACC_W:0] wide;
      wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      // The two top bits disagree only on overflow; the top bit then gives
      // the true sign and so the direction of the clamp.
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         if (wide[ACC_W])
            return {1'b1, {(ACC_W-1){1'b0}}};
         else
            return {1'b0, {(ACC_W-1){1'b1}}};
      end
      return wide[ACC_W-1:0];
`else
      return a + b;
`endif
   endfunction

   // Size casts of signed operands sign-extend.
   assign in_real_ext = ACC_W'(bus.in_real);
   assign in_imag_ext = ACC_W'(bus.in_imag);

   assign sum_real_d = acc_add(acc_real_q, in_real_ext);
   assign sum_imag_d = acc_add(acc_imag_q, in_imag_ext);

   // flush takes priority over an offered product in the same cycle.
   assign in_ready_w = (state_q == ACCUM) && !bus.flush;
   assign accept_w   = bus.in_valid && in_ready_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         acc_real_q <= '0;
         acc_imag_q <= '0;
         out_real_q <= '0;
         out_imag_q <= '0;
         term_idx_q <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (bus.flush) begin
                  acc_real_q <= '0;
                  acc_imag_q <= '0;
                  term_idx_q <= '0;
               end else if (accept_w) begin
                  if (term_idx_q == LAST_IDX) begin
                     out_real_q <= sum_real_d;
                     out_imag_q <= sum_imag_d;
                     acc_real_q <= '0;
                     acc_imag_q <= '0;
                     term_idx_q <= '0;
                     state_q    <= HOLD;
                  end else begin
                     acc_real_q <= sum_real_d;
                     acc_imag_q <= sum_imag_d;
                     term_idx_q <= term_idx_q + TIDX_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready)
                  state_q <= ACCUM;
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_real  = out_real_q;
   assign bus.out_imag  = out_imag_q;
   assign bus.term_idx  = term_idx_q;

endmodule

// File: tb/tb_complex_dot_accumulator.sv
module tb_complex_dot_accumulator;

   localparam int K      = 4;
   localparam int IN_W   = 16;
   localparam int ACC_W  = 24;
   localparam int K8     = 8;
   localparam int ACC_W8 = 18;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   complex_dot_accumulator_if #(.K(K),  .IN_W(IN_W), .ACC_W(ACC_W))  bus ();
   complex_dot_accumulator_if #(.K(K8), .IN_W(IN_W), .ACC_W(ACC_W8)) bus8 ();

   complex_dot_accumulator #(.K(K), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   complex_dot_accumulator #(.K(K8), .IN_W(IN_W), .ACC_W(ACC_W8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   // Reference: sum a list of products step by step in the chosen width.
   function automatic longint ref_acc(input longint vals[$], input int w);
      longint lo, hi, m, s;
      m  = longint'(1) << w;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      s  = 0;
      foreach (vals[i]) begin
         s = s + vals[i];
`ifdef CDA_SATURATE_EN
         if (s > hi) s = hi;
         else if (s < lo) s = lo;
`else
         s = ((s % m) + m) % m;
         if (s > hi) s = s - m;
`endif
      end
      return s;
   endfunction

   task automatic drive(input logic v, input longint r, input longint i,
                        input logic fl, input logic ordy);
      bus.in_valid  = v;
      bus.in_real   = IN_W'(r);
      bus.in_imag   = IN_W'(i);
      bus.flush     = fl;
      bus.out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      bus8.in_valid = 1'b0; bus8.in_real = '0; bus8.in_imag = '0;
      bus8.flush = 1'b0; bus8.out_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.term_idx !== 2'd0) begin
         failures++;
         $display("FAIL reset_ctrl: out_valid=%0b in_ready=%0b term_idx=%0d, required 0 1 0",
                  bus.out_valid, bus.in_ready, bus.term_idx);
      end
      checks++;
      if (bus.out_real !== 24'sd0 || bus.out_imag !== 24'sd0) begin
         failures++;
         $display("FAIL reset_out: out=(%0d,%0d), required (0,0)", bus.out_real, bus.out_imag);
      end
   endtask

   task automatic test_basic();
      longint pr[4] = '{100, 200, -300, 1};
      longint pi[4] = '{-50, 25, 0, 1};
      for (int n = 0; n < 4; n++) begin
         checks++;
         if (bus.term_idx !== 2'(n)) begin
            failures++;
            $display("FAIL basic_term_idx: got %0d, required %0d", bus.term_idx, n);
         end
         drive(1'b1, pr[n], pi[n], 1'b0, 1'b0);
         tick();
         if (n < 3) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               failures++;
               $display("FAIL basic_early_valid: out_valid=%0b after product %0d, required 0",
                        bus.out_valid, n);
            end
         end
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.term_idx !== 2'd0) begin
         failures++;
         $display("FAIL basic_hold: out_valid=%0b in_ready=%0b term_idx=%0d, required 1 0 0",
                  bus.out_valid, bus.in_ready, bus.term_idx);
      end
      checks++;
      if (longint'(bus.out_real) !== 1 || longint'(bus.out_imag) !== -24) begin
         failures++;
         $display("FAIL basic_result: out=(%0d,%0d), required (1,-24)", bus.out_real, bus.out_imag);
      end
   endtask

   task automatic test_backpressure();
      longint qr[$], qi[$];
      longint er, ei;
      drive(1'b1, 55, 66, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
             longint'(bus.out_real) !== 1 || longint'(bus.out_imag) !== -24) begin
            failures++;
            $display("FAIL bp_stall: cycle %0d in_ready=%0b out_valid=%0b out=(%0d,%0d), required 0 1 (1,-24)",
                     n, bus.in_ready, bus.out_valid, bus.out_real, bus.out_imag);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.term_idx !== 2'd0) begin
         failures++;
         $display("FAIL bp_release: in_ready=%0b out_valid=%0b term_idx=%0d, required 1 0 0",
                  bus.in_ready, bus.out_valid, bus.term_idx);
      end
      for (int n = 0; n < 4; n++) begin
         logic signed [15:0] r, i;
         r = 16'($urandom);
         i = 16'($urandom);
         qr.push_back(longint'(r));
         qi.push_back(longint'(i));
         drive(1'b1, longint'(r), longint'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      er = ref_acc(qr, ACC_W);
      ei = ref_acc(qi, ACC_W);
      checks++;
      if (bus.out_valid !== 1'b1 || longint'(bus.out_real) !== er || longint'(bus.out_imag) !== ei) begin
         failures++;
         $display("FAIL bp_second_sum: out_valid=%0b out=(%0d,%0d), required 1 (%0d,%0d)",
                  bus.out_valid, bus.out_real, bus.out_imag, er, ei);
      end
      // hand-off cycle with a product offered: it must not be accepted
      drive(1'b1, 3, 3, 1'b0, 1'b1);
      tick();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (bus.term_idx !== 2'd0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_no_passthru: term_idx=%0d out_valid=%0b, required 0 0",
                  bus.term_idx, bus.out_valid);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 7, 7, 1'b0, 1'b0); tick();
      drive(1'b1, 8, 8, 1'b0, 1'b0); tick();
      checks++;
      if (bus.term_idx !== 2'd2) begin
         failures++;
         $display("FAIL flush_pre_idx: term_idx=%0d, required 2", bus.term_idx);
      end
      drive(1'b1, 9, 9, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_ready: in_ready=%0b, required 0", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.term_idx !== 2'd0) begin
         failures++;
         $display("FAIL flush_idx: term_idx=%0d, required 0", bus.term_idx);
      end
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, 1, 2, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || longint'(bus.out_real) !== 4 || longint'(bus.out_imag) !== 8) begin
         failures++;
         $display("FAIL flush_result: out_valid=%0b out=(%0d,%0d), required 1 (4,8)",
                  bus.out_valid, bus.out_real, bus.out_imag);
      end
      // flush while holding is ignored
      drive(1'b0, 0, 0, 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || longint'(bus.out_real) !== 4 || longint'(bus.out_imag) !== 8) begin
         failures++;
         $display("FAIL flush_in_hold: out_valid=%0b out=(%0d,%0d), required 1 (4,8)",
                  bus.out_valid, bus.out_real, bus.out_imag);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_mid_reset();
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, 1000 + n, -77, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.term_idx !== 2'd0) begin
         failures++;
         $display("FAIL midrst_state: out_valid=%0b term_idx=%0d, required 0 0",
                  bus.out_valid, bus.term_idx);
      end
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, 5, -5, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || longint'(bus.out_real) !== 20 || longint'(bus.out_imag) !== -20) begin
         failures++;
         $display("FAIL midrst_result: out_valid=%0b out=(%0d,%0d), required 1 (20,-20)",
                  bus.out_valid, bus.out_real, bus.out_imag);
      end
      // reset during HOLD discards the held result
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_real !== 24'sd0 || bus.out_imag !== 24'sd0) begin
         failures++;
         $display("FAIL holdrst: out_valid=%0b out=(%0d,%0d), required 0 (0,0)",
                  bus.out_valid, bus.out_real, bus.out_imag);
      end
   endtask

   task automatic test_extremes();
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, -32768, 32767, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (longint'(bus.out_real) !== -131072 || longint'(bus.out_imag) !== 131068) begin
         failures++;
         $display("FAIL extremes: out=(%0d,%0d), required (-131072,131068)",
                  bus.out_real, bus.out_imag);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      longint exp_r, exp_i;
`ifdef CDA_SATURATE_EN
      exp_r = 131071;  exp_i = -131072;
`else
      exp_r = -8;      exp_i = 0;
`endif
      for (int n = 0; n < 8; n++) begin
         bus8.in_valid = 1'b1;
         bus8.in_real  = 16'sd32767;
         bus8.in_imag  = -16'sd32768;
         tick();
      end
      bus8.in_valid = 1'b0;
      checks++;
      if (bus8.out_valid !== 1'b1 || longint'(bus8.out_real) !== exp_r ||
          longint'(bus8.out_imag) !== exp_i) begin
         failures++;
         $display("FAIL saturation: out_valid=%0b out=(%0d,%0d), required 1 (%0d,%0d)",
                  bus8.out_valid, bus8.out_real, bus8.out_imag, exp_r, exp_i);
      end
   endtask

   task automatic test_random();
      longint qr[$], qi[$];
      longint er = 0, ei = 0;
      bit     mhold = 1'b0;
      for (int c = 0; c < 300; c++) begin
         logic v, fl, ordy;
         logic signed [15:0] r, i;
         v    = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 15) == 0);
         ordy = ($urandom_range(0, 2) == 0);
         r    = 16'($urandom);
         i    = 16'($urandom);
         drive(v, longint'(r), longint'(i), fl, ordy);
         #1;
         checks++;
         if (bus.in_ready !== (!mhold && !fl)) begin
            failures++;
            $display("FAIL rand_ready: cycle %0d in_ready=%0b, required %0b",
                     c, bus.in_ready, (!mhold && !fl));
         end
         @(posedge clk);
         if (mhold) begin
            if (ordy) mhold = 1'b0;
         end else if (fl) begin
            qr.delete(); qi.delete();
         end else if (v) begin
            qr.push_back(longint'(r));
            qi.push_back(longint'(i));
            if (qr.size() == K) begin
               er = ref_acc(qr, ACC_W);
               ei = ref_acc(qi, ACC_W);
               qr.delete(); qi.delete();
               mhold = 1'b1;
            end
         end
         #1;
         checks++;
         if (bus.out_valid !== mhold || int'(bus.term_idx) != qr.size()) begin
            failures++;
            $display("FAIL rand_state: cycle %0d out_valid=%0b term_idx=%0d, required %0b %0d",
                     c, bus.out_valid, bus.term_idx, mhold, qr.size());
         end
         if (mhold) begin
            checks++;
            if (longint'(bus.out_real) !== er || longint'(bus.out_imag) !== ei) begin
               failures++;
               $display("FAIL rand_result: cycle %0d out=(%0d,%0d), required (%0d,%0d)",
                        c, bus.out_real, bus.out_imag, er, ei);
            end
         end
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_flush();
      test_mid_reset();
      test_extremes();
      test_saturation();
      rst = 1'b1; tick(); rst = 1'b0;
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/complex_dot_accumulator.md
Name: complex_dot_accumulator

Overview:
- Downstream stage of the complex multiplier element.
- Consumes a stream of 16-bit signed complex products and accumulates K of them into one complex dot-product term, which is one element of the result matrix.
- Presents each finished element on a valid/ready output and holds it until accepted.
- Sits between the multiplier array and the result-matrix writeback.

Parameters:
- K, 4, number of products summed per output element (inner matrix dimension); K >= 1.
- IN_W, 16, width of each signed product component.
- ACC_W, 24, width of the signed accumulator and output components; ACC_W >= IN_W + clog2(K).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_real  input  IN_W  signed real part of product.
- in_imag  input  IN_W  signed imaginary part of product.
- in_valid  input  1  product present.
- in_ready  output  1  block accepts product this cycle.
- flush  input  1  discard the partial sum.
- out_real  output  ACC_W  signed accumulated real part.
- out_imag  output  ACC_W  signed accumulated imaginary part.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- term_idx  output  clog2(K) (min 1)  index of the next product to be accepted.

Behaviour:
- Single clock, synchronous active-high reset. All state updates on the rising edge of clk.
- Reset values: acc_real = acc_imag = 0, out_real = out_imag = 0, out_valid = 0, term_idx = 0, state = ACCUM.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Accept condition: in_valid && in_ready. Inputs are sign-extended to ACC_W before adding.
- Accept with term_idx < K-1: acc += input; term_idx increments.
- Accept with term_idx == K-1:
  - out_real/out_imag <= acc + input.
  - acc <= 0, term_idx <= 0, state <= HOLD.
  - out_valid is 1 the next cycle, so latency is 1 cycle after the last product.
- K == 1: every accepted product goes straight to HOLD.
- HOLD: outputs are stable while out_ready = 0. out_valid && out_ready returns the block to ACCUM next cycle. No product is accepted in the cycle the result is taken (no pass-through), so the maximum rate is one result per K+1 cycles.
- flush in ACCUM: acc <= 0, term_idx <= 0. A product offered in the same cycle is not accepted; flush wins and in_ready is forced to 0 that cycle.
- flush in HOLD: ignored; the held result is still delivered.
- rst mid-accumulation or during HOLD: the partial sum and the held result are discarded and all reset values apply next cycle.
- Arithmetic is two's complement and wraps at ACC_W unless the optional feature is enabled.
- in_valid without acceptance has no effect. Products are never duplicated or dropped, except by flush or rst.

Optional Feature:
- Macro: CDA_SATURATE_EN.
- Defined: each accumulation step (including the final add into out_*) clamps independently per component to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]. Once a component is clamped it continues from the clamped value.
- Undefined: plain wrap-around addition, with no extra logic.

Test Plan:
- Reset/basic, K=4: products (100,-50), (200,25), (-300,0), (1,1) on consecutive cycles -> out_valid rises 1 cycle after the 4th product with out = (1,-24); term_idx sequence 0,1,2,3,0.
- Backpressure: hold out_ready = 0 for 5 cycles while in_valid stays 1 -> in_ready = 0 and out stays (1,-24); out_ready = 1 -> next cycle in_ready = 1 and the following 4 products form a new, independent sum.
- Flush: after 2 products (7,7),(8,8), assert flush together with in_valid carrying (9,9) -> (9,9) not accepted, term_idx = 0; then (1,2)x4 -> out = (4,8).
- Mid-operation reset: rst after 3 products -> out_valid = 0, term_idx = 0; the next 4 products (5,-5) give out = (20,-20).
- Extremes, K=4, ACC_W=24: four (-32768,32767) -> out = (-131072,131068).
- Saturation, K=8, ACC_W=18: eight (32767,-32768):
  - With CDA_SATURATE_EN: out = (131071,-131072).
  - Without it: out = (-8,0).
